lo_edge_detect_hyst: RTL

//  LF edge detector, parametrised successor of the fixed-threshold LF edge path.

---
 rtl/lo_edge_detect_hyst_if.sv | 33 +++
 rtl/lo_edge_detect_hyst.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lo_edge_detect_hyst_if.sv
// Signal bundle for the LF edge detector: configuration, ADC sample and edge status.
// master = controller/ADC side, slave = the detector.
interface lo_edge_detect_hyst_if #(
   parameter int unsigned ADC_W   = 8,
   parameter int unsigned DIV_W   = 8,
   parameter int unsigned DWELL_W = 4,
   parameter int unsigned CNT_W   = 16
);
   logic               enable;
   logic [DIV_W-1:0]   divisor;
   logic [ADC_W-1:0]   adc_d;
   logic [ADC_W-1:0]   thr_hi;
   logic [ADC_W-1:0]   thr_lo;
   logic [DWELL_W-1:0] min_dwell;
   logic               adc_clk;
   logic               edge_state;
   logic               edge_rise;
   logic               edge_fall;
   logic [CNT_W-1:0]   interval;
   logic               interval_vld;
   logic               overflow;
   logic               cfg_err;

   modport master (
      output enable, divisor, adc_d, thr_hi, thr_lo, min_dwell,
      input  adc_clk, edge_state, edge_rise, edge_fall, interval, interval_vld, overflow, cfg_err
   );

   modport slave (
      input  enable, divisor, adc_d, thr_hi, thr_lo, min_dwell,
      output adc_clk, edge_state, edge_rise, edge_fall, interval, interval_vld, overflow, cfg_err
   );
endinterface

// File: rtl/lo_edge_detect_hyst.sv
// LF edge detector: adc_clk divider, once-per-period sampling, hysteresis comparator with
// dwell filter and edge-interval counter. Define LF_EDGE_AVG_EN to compare a 4-sample average.
module lo_edge_detect_hyst #(
   parameter int unsigned ADC_W         = 8,
   parameter int unsigned DIV_W         = 8,
   parameter int unsigned DWELL_W       = 4,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned SAMPLE_OFFSET = 7
) (
   input logic                  pck0,
   input logic                  nrst,
   lo_edge_detect_hyst_if.slave bus
);

   typedef enum logic [1:0] {StLow, StRisePend, StHigh, StFallPend} state_e;

   localparam logic [DIV_W-1:0] Offset = DIV_W'(SAMPLE_OFFSET);

   // ---------------------------------------------------------------- divider
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic             clk_state_q, clk_state_d;
   logic [DIV_W-1:0] strobe_pt;
   logic             strobe;

   always_comb begin
      div_cnt_d   = div_cnt_q + 1'b1;
      clk_state_d = clk_state_q;
      // A divisor lowered below the running count wraps through all-ones.
      if (div_cnt_q == bus.divisor) begin
         div_cnt_d   = '0;
         clk_state_d = ~clk_state_q;
      end
   end

   assign strobe_pt   = (bus.divisor < Offset) ? bus.divisor : Offset;
   assign strobe      = bus.enable & ~clk_state_q & (div_cnt_q == strobe_pt);
   assign bus.adc_clk = ~clk_state_q;

   // --------------------------------------------------------- comparator input
   logic [ADC_W-1:0] sample;

`ifdef LF_EDGE_AVG_EN
   localparam int unsigned SumW = ADC_W + 2;

   logic [ADC_W-1:0] hist0_q, hist1_q, hist2_q;
   logic [SumW-1:0]  avg_sum;

   assign avg_sum = SumW'(bus.adc_d) + SumW'(hist0_q) + SumW'(hist1_q) + SumW'(hist2_q);
   assign sample  = avg_sum[SumW-1:2];

   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) begin
         hist0_q <= '0;
         hist1_q <= '0;
         hist2_q <= '0;
      end else if (!bus.enable) begin
         hist0_q <= '0;
         hist1_q <= '0;
         hist2_q <= '0;
      end else if (strobe) begin
         hist0_q <= bus.adc_d;
         hist1_q <= hist0_q;
         hist2_q <= hist1_q;
      end
   end
`else
   assign sample = bus.adc_d;
`endif

   logic above, below, cfg_err;

   assign above       = sample >= bus.thr_hi;
   assign below       = sample <= bus.thr_lo;
   assign cfg_err     = bus.thr_lo >= bus.thr_hi;
   assign bus.cfg_err = cfg_err;

   // ---------------------------------------------------------------- FSM
   state_e             state_q, state_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W:0]   dwell_inc;
   logic               dwell_met, first_met;
   logic               rise, fall, commit;

   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      rise      = 1'b0;
      fall      = 1'b0;
      dwell_inc = {1'b0, dwell_q} + 1'b1;
      dwell_met = dwell_inc >= {1'b0, bus.min_dwell};
      first_met = bus.min_dwell <= DWELL_W'(1);
      // An inverted threshold pair freezes the FSM, pending dwell included.
      if (strobe && !cfg_err) begin
         case (state_q)
            StLow: begin
               if (above) begin
                  if (first_met) begin
                     state_d = StHigh;
                     rise    = 1'b1;
                  end else begin
                     state_d = StRisePend;
                     dwell_d = DWELL_W'(1);
                  end
               end
            end
            StRisePend: begin
               if (!above) begin
                  state_d = StLow;
                  dwell_d = '0;
               end else if (dwell_met) begin
                  state_d = StHigh;
                  dwell_d = '0;
                  rise    = 1'b1;
               end else begin
                  dwell_d = dwell_inc[DWELL_W-1:0];
               end
            end
            StHigh: begin
               if (below) begin
                  if (first_met) begin
                     state_d = StLow;
                     fall    = 1'b1;
                  end else begin
                     state_d = StFallPend;
                     dwell_d = DWELL_W'(1);
                  end
               end
            end
            StFallPend: begin
               if (!below) begin
                  state_d = StHigh;
                  dwell_d = '0;
               end else if (dwell_met) begin
                  state_d = StLow;
                  dwell_d = '0;
                  fall    = 1'b1;
               end else begin
                  dwell_d = dwell_inc[DWELL_W-1:0];
               end
            end
            default: begin
               state_d = StLow;
               dwell_d = '0;
            end
         endcase
      end
   end

   assign commit = rise | fall;

   // ------------------------------------------------------ interval counter
   logic [CNT_W-1:0] count_q, count_d, count_inc;
   logic [CNT_W-1:0] interval_q, interval_d;
   logic             count_sat;
   logic             overflow_q, overflow_d;
   logic             interval_vld_q;
   logic             edge_state_q, edge_state_d;
   logic             edge_rise_q, edge_fall_q;

   always_comb begin
      count_sat  = &count_q;
      count_inc  = count_sat ? count_q : count_q + 1'b1;
      count_d    = count_q;
      interval_d = interval_q;
      overflow_d = overflow_q;
      // Overflow stays visible alongside interval_vld, then clears.
      if (interval_vld_q) overflow_d = 1'b0;
      if (strobe) begin
         if (count_sat) overflow_d = 1'b1;
         if (commit) begin
            interval_d = count_inc;
            count_d    = '0;
         end else begin
            count_d = count_inc;
         end
      end
      edge_state_d = rise ? 1'b1 : (fall ? 1'b0 : edge_state_q);
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge pck0 or negedge nrst) begin
      if (!nrst) begin
         div_cnt_q      <= '0;
         clk_state_q    <= 1'b0;
         state_q        <= StLow;
         dwell_q        <= '0;
         count_q        <= '0;
         interval_q     <= '0;
         overflow_q     <= 1'b0;
         interval_vld_q <= 1'b0;
         edge_state_q   <= 1'b0;
         edge_rise_q    <= 1'b0;
         edge_fall_q    <= 1'b0;
      end else if (!bus.enable) begin
         div_cnt_q      <= '0;
         clk_state_q    <= 1'b0;
         state_q        <= StLow;
         dwell_q        <= '0;
         count_q        <= '0;
         interval_q     <= '0;
         overflow_q     <= 1'b0;
         interval_vld_q <= 1'b0;
         edge_state_q   <= 1'b0;
         edge_rise_q    <= 1'b0;
         edge_fall_q    <= 1'b0;
      end else begin
         div_cnt_q      <= div_cnt_d;
         clk_state_q    <= clk_state_d;
         state_q        <= state_d;
         dwell_q        <= dwell_d;
         count_q        <= count_d;
         interval_q     <= interval_d;
         overflow_q     <= overflow_d;
         interval_vld_q <= commit;
         edge_state_q   <= edge_state_d;
         edge_rise_q    <= rise;
         edge_fall_q    <= fall;
      end
   end

   assign bus.edge_state   = edge_state_q;
   assign bus.edge_rise    = edge_rise_q;
   assign bus.edge_fall    = edge_fall_q;
   assign bus.interval     = interval_q;
   assign bus.interval_vld = interval_vld_q;
   assign bus.overflow     = overflow_q;

endmodule
